nback_game_core: RTL and testbench



---
 rtl/nback_game_core.sv | 239 +++++++++++++++++++++++
 tb/tb_nback_game_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nback_game_core.sv
// N-back memory game engine: LFSR card generator, per-card countdown timer,
// answer latch, scoring with speed-up levels and a best-score register.
module nback_game_core #(
  parameter int unsigned CARD_W      = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned NBACK_MAX   = 3,
  parameter int unsigned TICK_W      = 28,
  parameter int unsigned SPEED_INIT  = 149_999_999,
  parameter int unsigned SPEED_STEP  = 12_500_000,
  parameter int unsigned SPEED_MIN   = 24_999_999,
  parameter int unsigned LEVEL_EVERY = 4,
  parameter int unsigned SCORE_W     = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               ans_match,
  input  logic               ans_nomatch,
  input  logic [2:0]         nback_sel,
  output logic [CARD_W-1:0]  card,
  output logic               card_valid,
  output logic               answer_open,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic [3:0]         level,
  output logic               correct_pulse,
  output logic               wrong_pulse,
  output logic               game_over,
  output logic               game_won
);

  localparam int unsigned K_W      = 8;
  localparam int unsigned STREAK_W = $clog2(LEVEL_EVERY + 1);
  localparam int unsigned HIST_N   = NBACK_MAX + 1;
  localparam int unsigned RW       = TICK_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_SHOW, S_JUDGE, S_OVER, S_WIN} state_e;
  typedef enum logic [1:0] {A_NONE, A_MATCH, A_NOMATCH, A_INVALID} ans_e;

  state_e                state_q, state_d;
  ans_e                  latch_q, latch_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [CARD_W-1:0]     hist_q [HIST_N];
  logic [CARD_W-1:0]     hist_d [HIST_N];
  logic [TICK_W-1:0]     timer_q, timer_d;
  logic [TICK_W-1:0]     reload_q, reload_d;
  logic [2:0]            n_q, n_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [SCORE_W-1:0]    best_q, best_d;
  logic [3:0]            level_q, level_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  m_prev_q, m_prev_d;
  logic                  nm_prev_q, nm_prev_d;
  logic                  correct_q, correct_d;
  logic                  wrong_q, wrong_d;
  logic                  card_valid_q, card_valid_d;
  logic                  answer_open_q, answer_open_d;
  logic                  over_q, over_d;
  logic                  won_q, won_d;

  logic                  rise_m, rise_nm, gen, scored, forced;
  logic [STREAK_W-1:0]   streak_inc;
  logic [CARD_W-1:0]     hist_n, hist_nm1, new_card;
  ans_e                  exp_ans;

  // Registered state, datapath and outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      latch_q       <= A_NONE;
      lfsr_q        <= SEED;
      timer_q       <= '0;
      reload_q      <= TICK_W'(SPEED_INIT);
      n_q           <= '0;
      k_q           <= '0;
      score_q       <= '0;
      best_q        <= '0;
      level_q       <= '0;
      streak_q      <= '0;
      m_prev_q      <= 1'b0;
      nm_prev_q     <= 1'b0;
      correct_q     <= 1'b0;
      wrong_q       <= 1'b0;
      card_valid_q  <= 1'b0;
      answer_open_q <= 1'b0;
      over_q        <= 1'b0;
      won_q         <= 1'b0;
      for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      latch_q       <= latch_d;
      lfsr_q        <= lfsr_d;
      timer_q       <= timer_d;
      reload_q      <= reload_d;
      n_q           <= n_d;
      k_q           <= k_d;
      score_q       <= score_d;
      best_q        <= best_d;
      level_q       <= level_d;
      streak_q      <= streak_d;
      m_prev_q      <= m_prev_d;
      nm_prev_q     <= nm_prev_d;
      correct_q     <= correct_d;
      wrong_q       <= wrong_d;
      card_valid_q  <= card_valid_d;
      answer_open_q <= answer_open_d;
      over_q        <= over_d;
      won_q         <= won_d;
      hist_q        <= hist_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d    = state_q;
    latch_d    = latch_q;
    lfsr_d     = lfsr_q;
    hist_d     = hist_q;
    timer_d    = timer_q;
    reload_d   = reload_q;
    n_d        = n_q;
    k_d        = k_q;
    score_d    = score_q;
    best_d     = best_q;
    level_d    = level_q;
    streak_d   = streak_q;
    m_prev_d   = ans_match;
    nm_prev_d  = ans_nomatch;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    gen        = 1'b0;
    forced     = 1'b0;
    new_card   = '0;
    hist_n     = '0;
    hist_nm1   = '0;
    streak_inc = streak_q + STREAK_W'(1);
    rise_m     = ans_match & ~m_prev_q;
    rise_nm    = ans_nomatch & ~nm_prev_q;
    scored     = (k_q >= K_W'(n_q));

    for (int i = 0; i < HIST_N; i++) begin
      if (n_q == 3'(i)) hist_n = hist_q[i];
    end
    exp_ans = (hist_n == hist_q[0]) ? A_MATCH : A_NOMATCH;

    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          state_d  = S_SHOW;
          if (nback_sel == 3'd0)                 n_d = 3'd1;
          else if (nback_sel > 3'(NBACK_MAX))    n_d = 3'(NBACK_MAX);
          else                                   n_d = nback_sel;
          score_d  = '0;
          streak_d = '0;
          level_d  = '0;
          k_d      = '0;
          reload_d = TICK_W'(SPEED_INIT);
          timer_d  = TICK_W'(SPEED_INIT);
          gen      = 1'b1;
        end
      end
      S_SHOW: begin
        if (latch_q == A_NONE) begin
          if (rise_m && rise_nm) latch_d = A_INVALID;
          else if (rise_m)       latch_d = A_MATCH;
          else if (rise_nm)      latch_d = A_NOMATCH;
        end
        if (timer_q == '0) state_d = S_JUDGE;
        else               timer_d = timer_q - TICK_W'(1);
      end
      S_JUDGE: begin
        if (scored && (latch_q != exp_ans)) begin
          wrong_d = 1'b1;
          state_d = S_OVER;
          if (score_q > best_q) best_d = score_q;
        end else begin
          if (scored) begin
            correct_d = 1'b1;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
            if (streak_inc == STREAK_W'(LEVEL_EVERY)) begin
              streak_d = '0;
              if (level_q != 4'hF) level_d = level_q + 4'd1;
              // Floor the reload without letting the subtraction wrap
              if (RW'(reload_q) >= RW'(SPEED_MIN) + RW'(SPEED_STEP))
                reload_d = reload_q - TICK_W'(SPEED_STEP);
              else
                reload_d = TICK_W'(SPEED_MIN);
            end else begin
              streak_d = streak_inc;
            end
          end
          if (k_q == K_W'(DEPTH - 1)) begin
            state_d = S_WIN;
            if (score_d > best_q) best_d = score_d;
          end else begin
            state_d = S_SHOW;
            k_d     = k_q + K_W'(1);
            timer_d = reload_d;
            gen     = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Draw the next card: forced repeat of the card N back, else LFSR bits
    if (gen) begin
      for (int i = 0; i < NBACK_MAX; i++) begin
        if (n_d == 3'(i + 1)) hist_nm1 = hist_q[i];
      end
      forced   = (k_d >= K_W'(n_d)) && (lfsr_q[15:14] == 2'b00);
      new_card = forced ? hist_nm1 : lfsr_q[CARD_W-1:0];
      for (int i = HIST_N - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = new_card;
      lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end

    if ((state_d == S_SHOW) && (state_q != S_SHOW)) latch_d = A_NONE;

    card_valid_d  = (state_d == S_SHOW) || (state_d == S_JUDGE);
    answer_open_d = (state_d == S_SHOW) && (k_d >= K_W'(n_d));
    over_d        = (state_d == S_OVER);
    won_d         = (state_d == S_WIN);
  end

  assign card          = hist_q[0];
  assign card_valid    = card_valid_q;
  assign answer_open   = answer_open_q;
  assign score         = score_q;
  assign best_score    = best_q;
  assign level         = level_q;
  assign correct_pulse = correct_q;
  assign wrong_pulse   = wrong_q;
  assign game_over     = over_q;
  assign game_won      = won_q;

endmodule

// File: tb/tb_nback_game_core.sv
// Directed bench for nback_game_core: short timer, 8-card games, several N values.
module tb_nback_game_core;

  localparam int unsigned CARD_W      = 4;
  localparam int unsigned DEPTH       = 8;
  localparam int unsigned NBACK_MAX   = 3;
  localparam int unsigned TICK_W      = 8;
  localparam int unsigned SPEED_INIT  = 9;
  localparam int unsigned SPEED_STEP  = 4;
  localparam int unsigned SPEED_MIN   = 3;
  localparam int unsigned LEVEL_EVERY = 2;
  localparam int unsigned SCORE_W     = 8;
  localparam logic [15:0] SEED        = 16'hACE1;

  logic               clk = 1'b0;
  logic               resetn = 1'b1;
  logic               start = 1'b0;
  logic               ans_match = 1'b0;
  logic               ans_nomatch = 1'b0;
  logic [2:0]         nback_sel = 3'd0;
  logic [CARD_W-1:0]  card;
  logic               card_valid, answer_open;
  logic [SCORE_W-1:0] score, best_score;
  logic [3:0]         level;
  logic               correct_pulse, wrong_pulse, game_over, game_won;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model state
  logic [15:0]       m_lfsr = SEED;
  logic [CARD_W-1:0] m_hist [4] = '{default: '0};
  logic [CARD_W-1:0] m_card = '0;
  int                m_k = 0;
  int                m_n = 1;
  int                m_score = 0;

  nback_game_core #(
    .CARD_W(CARD_W), .DEPTH(DEPTH), .NBACK_MAX(NBACK_MAX), .TICK_W(TICK_W),
    .SPEED_INIT(SPEED_INIT), .SPEED_STEP(SPEED_STEP), .SPEED_MIN(SPEED_MIN),
    .LEVEL_EVERY(LEVEL_EVERY), .SCORE_W(SCORE_W), .SEED(SEED)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .ans_match(ans_match),
    .ans_nomatch(ans_nomatch), .nback_sel(nback_sel), .card(card),
    .card_valid(card_valid), .answer_open(answer_open), .score(score),
    .best_score(best_score), .level(level), .correct_pulse(correct_pulse),
    .wrong_pulse(wrong_pulse), .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_gen();
    logic forced;
    forced = (m_k >= m_n) && (m_lfsr[15:14] == 2'b00);
    m_card = forced ? m_hist[m_n-1] : m_lfsr[CARD_W-1:0];
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_card;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic start_game(input logic [2:0] sel, input int exp_n, input string tag);
    nback_sel = sel;
    start = 1'b1;
    step();
    start = 1'b0;
    m_n = exp_n;
    m_k = 0;
    m_score = 0;
    m_gen();
    chk({tag, " valid"}, 32'(card_valid), 32'd1);
    chk({tag, " score"}, 32'(score), 32'd0);
    chk({tag, " level"}, 32'(level), 32'd0);
    chk({tag, " status"}, 32'({game_over, game_won}), 32'd0);
  endtask

  // kind: 0 none, 1 correct, 2 wrong, 3 both at once, 4 correct then wrong, 5 correct with start
  task automatic play_card(input int kind, input int exp_period, input string tag);
    int   cnt;
    logic exp_match, scored, good;
    cnt = 0;
    scored = (m_k >= m_n);
    exp_match = (m_hist[0] == m_hist[m_n]);
    chk({tag, " card"}, 32'(card), 32'(m_card));
    chk({tag, " open"}, 32'(answer_open), 32'(scored));
    case (kind)
      1, 4, 5: begin
        start = (kind == 5);
        if (exp_match) ans_match = 1'b1; else ans_nomatch = 1'b1;
        step(); cnt++;
        ans_match = 1'b0; ans_nomatch = 1'b0; start = 1'b0;
        if (kind == 4) begin
          step(); cnt++;
          if (exp_match) ans_nomatch = 1'b1; else ans_match = 1'b1;
          step(); cnt++;
          ans_match = 1'b0; ans_nomatch = 1'b0;
        end
      end
      2: begin
        if (exp_match) ans_nomatch = 1'b1; else ans_match = 1'b1;
        step(); cnt++;
        ans_match = 1'b0; ans_nomatch = 1'b0;
      end
      3: begin
        ans_match = 1'b1; ans_nomatch = 1'b1;
        step(); cnt++;
        ans_match = 1'b0; ans_nomatch = 1'b0;
      end
      default: ;
    endcase
    if (scored) begin
      while (!(correct_pulse || wrong_pulse) && cnt < 64) begin
        step(); cnt++;
      end
      good = (kind == 1) || (kind == 4) || (kind == 5);
      chk({tag, " period"}, 32'(cnt), 32'(exp_period));
      chk({tag, " correct_pulse"}, 32'(correct_pulse), 32'(good));
      chk({tag, " wrong_pulse"}, 32'(wrong_pulse), 32'(!good));
      if (good) begin
        m_score++;
        chk({tag, " score"}, 32'(score), 32'(m_score));
        if (m_k != DEPTH - 1) begin
          m_k++;
          m_gen();
        end
      end
    end else begin
      while (cnt < exp_period) begin
        step(); cnt++;
      end
      chk({tag, " warmup pulses"}, 32'({correct_pulse, wrong_pulse}), 32'd0);
      m_k++;
      m_gen();
    end
  endtask

  initial begin
    // Reset
    #3 resetn = 1'b0;
    #1;
    chk("reset card", 32'(card), 32'd0);
    chk("reset flags", 32'({card_valid, answer_open, correct_pulse, wrong_pulse, game_over, game_won}), 32'd0);
    chk("reset score", 32'({score, best_score, level}), 32'd0);
    step(); step();
    @(negedge clk) resetn = 1'b1;
    step();

    // Game A: nback_sel=0 gives N=1, no answers -> timeout on card 1
    start_game(3'd0, 1, "A start");
    chk("A first card is SEED[3:0]", 32'(card), 32'h1);
    play_card(0, 11, "A c0");
    play_card(0, 11, "A c1");
    chk("A over", 32'(game_over), 32'd1);
    chk("A valid low", 32'(card_valid), 32'd0);
    chk("A score", 32'(score), 32'd0);
    chk("A card held", 32'(card), 32'(m_card));
    step();
    chk("A wrong one cycle", 32'(wrong_pulse), 32'd0);
    chk("A still over", 32'(game_over), 32'd1);

    // Game B: N=1, all correct, levels 9->5->3->3, win
    start_game(3'd1, 1, "B start");
    play_card(0, 11, "B c0");
    play_card(1, 11, "B c1");
    play_card(1, 11, "B c2");
    chk("B level1", 32'(level), 32'd1);
    play_card(5, 7, "B c3");
    play_card(4, 7, "B c4");
    chk("B level2", 32'(level), 32'd2);
    play_card(1, 5, "B c5");
    play_card(1, 5, "B c6");
    play_card(1, 5, "B c7");
    chk("B won", 32'(game_won), 32'd1);
    chk("B valid low", 32'(card_valid), 32'd0);
    chk("B score", 32'(score), 32'd7);
    chk("B level3", 32'(level), 32'd3);
    chk("B best", 32'(best_score), 32'd7);

    // Game C: nback_sel=7 clamps to N=3, warm-up answers ignored, double press
    start_game(3'd7, 3, "C start");
    play_card(2, 11, "C c0");
    play_card(0, 11, "C c1");
    play_card(0, 11, "C c2");
    play_card(3, 11, "C c3");
    chk("C over", 32'({game_over, game_won}), 32'b10);
    chk("C score", 32'(score), 32'd0);
    chk("C best kept", 32'(best_score), 32'd7);

    // Game D: N=2, one correct then a wrong answer
    start_game(3'd2, 2, "D start");
    play_card(0, 11, "D c0");
    play_card(0, 11, "D c1");
    play_card(1, 11, "D c2");
    play_card(2, 11, "D c3");
    chk("D over", 32'(game_over), 32'd1);
    chk("D score", 32'(score), 32'd1);
    chk("D best kept", 32'(best_score), 32'd7);

    // Game E: score 5, then asynchronous reset mid-SHOW
    start_game(3'd1, 1, "E start");
    play_card(0, 11, "E c0");
    play_card(1, 11, "E c1");
    play_card(1, 11, "E c2");
    play_card(1, 7, "E c3");
    play_card(1, 7, "E c4");
    play_card(1, 5, "E c5");
    chk("E score5", 32'(score), 32'd5);
    chk("E best7", 32'(best_score), 32'd7);
    chk("E level2", 32'(level), 32'd2);
    #2 resetn = 1'b0;
    #1;
    chk("E rst card", 32'(card), 32'd0);
    chk("E rst flags", 32'({card_valid, answer_open, correct_pulse, wrong_pulse, game_over, game_won}), 32'd0);
    chk("E rst score", 32'(score), 32'd0);
    chk("E rst best", 32'(best_score), 32'd0);
    chk("E rst level", 32'(level), 32'd0);
    m_lfsr = SEED;
    m_hist = '{default: '0};
    step();
    @(negedge clk) resetn = 1'b1;
    step(); step();
    chk("E idle", 32'({card_valid, game_over, game_won}), 32'd0);
    start_game(3'd1, 1, "F start");
    chk("F card reseeded", 32'(card), 32'h1);
    play_card(0, 11, "F c0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
